// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: N-master / M-slave bus arbiter with split parking,
// top-priority resume, fixed or round-robin selection and bus-hold timeout.

// Per-master qualification: may this master start a fresh ownership, or
// resume one that was parked by a split?
module bus_arbiter_n_lane #(
  parameter int NUM_SLAVES = 3,
  parameter int SLAVE_LEN  = 2
) (
  input  logic                      request_i,
  input  logic [SLAVE_LEN-1:0]      sel_i,
  input  logic                      parked_i,
  input  logic [SLAVE_LEN-1:0]      park_slave_i,
  input  logic [(1<<SLAVE_LEN)-1:0] blocked_i,
  input  logic [(1<<SLAVE_LEN)-1:0] split_i,
  output logic                      eligible_o,
  output logic                      resumable_o
);
  localparam logic [SLAVE_LEN:0] NS = (SLAVE_LEN+1)'(NUM_SLAVES);

  logic in_range;

  // Out-of-range selects and slaves reserved by a parked master are refused.
  assign in_range    = {1'b0, sel_i} < NS;
  assign eligible_o  = request_i & ~parked_i & in_range & ~blocked_i[sel_i];
  assign resumable_o = parked_i & ~split_i[park_slave_i];
endmodule

module bus_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int SLAVE_LEN   = 2,
  parameter int RR_MODE     = 0,
  parameter int MAX_HOLD    = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_MASTERS-1:0]           request,
  input  logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_sel,
  input  logic                             trans_done,
  input  logic [NUM_SLAVES-1:0]            slave_split_en,
  output logic [NUM_MASTERS-1:0]           grant,
  output logic [SLAVE_LEN-1:0]             granted_slave,
  output logic                             arbiter_busy,
  output logic                             bus_busy,
  output logic [NUM_MASTERS-1:0]           split_parked,
  output logic                             timeout
);
  localparam int          MW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int          SS        = 1 << SLAVE_LEN;
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e                                  state_q, state_d;
  logic [NUM_MASTERS-1:0]                  parked_q, parked_d;
  logic [NUM_MASTERS-1:0][SLAVE_LEN-1:0]   park_slave_q, park_slave_d;
  logic [MW-1:0]                           owner_q, owner_d;
  logic [MW-1:0]                           rr_ptr_q, rr_ptr_d;
  logic [SLAVE_LEN-1:0]                    owner_slave_q, owner_slave_d;
  logic [15:0]                             hold_cnt_q, hold_cnt_d;
  logic [NUM_MASTERS-1:0]                  grant_q, grant_d;
  logic [SLAVE_LEN-1:0]                    granted_slave_q, granted_slave_d;
  logic                                    arbiter_busy_q, arbiter_busy_d;
  logic                                    bus_busy_q, bus_busy_d;
  logic                                    timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0][SLAVE_LEN-1:0]   sel_arr;
  logic [SS-1:0]                           blocked, split_ext;
  logic [NUM_MASTERS-1:0]                  eligible, resumable;
  logic                                    res_found, lo_found, hi_found;
  logic [MW-1:0]                           res_idx, lo_idx, hi_idx, elig_idx, next_ptr;

  assign sel_arr = slave_sel;

  // Slaves currently reserved by parked masters, and the split vector widened
  // to the full select space so any select value indexes it safely.
  always_comb begin
    blocked   = '0;
    split_ext = '0;
    split_ext[NUM_SLAVES-1:0] = slave_split_en;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (parked_q[i]) blocked[park_slave_q[i]] = 1'b1;
  end

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_lane
    bus_arbiter_n_lane #(.NUM_SLAVES(NUM_SLAVES), .SLAVE_LEN(SLAVE_LEN)) u_lane (
      .request_i    (request[g]),
      .sel_i        (sel_arr[g]),
      .parked_i     (parked_q[g]),
      .park_slave_i (park_slave_q[g]),
      .blocked_i    (blocked),
      .split_i      (split_ext),
      .eligible_o   (eligible[g]),
      .resumable_o  (resumable[g])
    );
  end

  // Winner search: lowest resumable; lowest eligible overall; lowest eligible
  // at or above rr_ptr (falls back to overall lowest to model wrap-around).
  always_comb begin
    res_found = 1'b0;
    lo_found  = 1'b0;
    hi_found  = 1'b0;
    res_idx   = '0;
    lo_idx    = '0;
    hi_idx    = '0;
    for (int i = NUM_MASTERS-1; i >= 0; i--) begin
      if (resumable[i]) begin
        res_found = 1'b1;
        res_idx   = MW'(i);
      end
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_idx   = MW'(i);
        if (MW'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = MW'(i);
        end
      end
    end
    elig_idx = (RR_MODE != 0 && hi_found) ? hi_idx : lo_idx;
    next_ptr = (owner_q == MW'(NUM_MASTERS-1)) ? '0 : owner_q + 1'b1;
  end

  // Next-state and next-output computation for the IDLE/OWNED machine.
  always_comb begin
    state_d       = state_q;
    parked_d      = parked_q;
    park_slave_d  = park_slave_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    owner_slave_d = owner_slave_q;
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (res_found) begin
          state_d           = OWNED;
          owner_d           = res_idx;
          owner_slave_d     = park_slave_q[res_idx];
          parked_d[res_idx] = 1'b0;
          hold_cnt_d        = '0;
        end else if (lo_found) begin
          state_d       = OWNED;
          owner_d       = elig_idx;
          owner_slave_d = sel_arr[elig_idx];
          hold_cnt_d    = '0;
        end
      end
      default: begin
        if (trans_done) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (split_ext[owner_slave_q]) begin
          // Owner keeps its slave reserved until the split clears.
          state_d               = IDLE;
          parked_d[owner_q]     = 1'b1;
          park_slave_d[owner_q] = owner_slave_q;
        end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          rr_ptr_d  = next_ptr;
        end else if (hold_cnt_q != 16'hffff) begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
    endcase

    grant_d         = '0;
    granted_slave_d = '0;
    arbiter_busy_d  = (state_d == OWNED);
    if (state_d == OWNED) begin
      grant_d[owner_d] = 1'b1;
      granted_slave_d  = owner_slave_d;
    end
    bus_busy_d = arbiter_busy_d | (|parked_d);
  end

  // State and registered outputs; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      parked_q        <= '0;
      park_slave_q    <= '0;
      owner_q         <= '0;
      rr_ptr_q        <= '0;
      owner_slave_q   <= '0;
      hold_cnt_q      <= '0;
      grant_q         <= '0;
      granted_slave_q <= '0;
      arbiter_busy_q  <= 1'b0;
      bus_busy_q      <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      parked_q        <= parked_d;
      park_slave_q    <= park_slave_d;
      owner_q         <= owner_d;
      rr_ptr_q        <= rr_ptr_d;
      owner_slave_q   <= owner_slave_d;
      hold_cnt_q      <= hold_cnt_d;
      grant_q         <= grant_d;
      granted_slave_q <= granted_slave_d;
      arbiter_busy_q  <= arbiter_busy_d;
      bus_busy_q      <= bus_busy_d;
      timeout_q       <= timeout_d;
    end
  end

  assign grant         = grant_q;
  assign granted_slave = granted_slave_q;
  assign arbiter_busy  = arbiter_busy_q;
  assign bus_busy      = bus_busy_q;
  assign split_parked  = parked_q;
  assign timeout       = timeout_q;
endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb_bus_arbiter_n: two arbiter instances (2-master fixed priority, and
// 3-master round robin with MAX_HOLD=5), directed vectors plus random
// stimulus against a behavioural model.
module tb_bus_arbiter_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: NUM_MASTERS=2, RR_MODE=0, MAX_HOLD=0
  logic       rst0, td0, ab0, bb0, to0;
  logic [1:0] req0, g0, gs0, spk0;
  logic [3:0] sel0;
  logic [2:0] sp0;
  // instance 1: NUM_MASTERS=3, RR_MODE=1, MAX_HOLD=5
  logic       rst1, td1, ab1, bb1, to1;
  logic [2:0] req1, g1, spk1, sp1;
  logic [1:0] gs1;
  logic [5:0] sel1;

  bus_arbiter_n #(.NUM_MASTERS(2), .NUM_SLAVES(3), .SLAVE_LEN(2), .RR_MODE(0), .MAX_HOLD(0)) dut0 (
    .clk(clk), .reset(rst0), .request(req0), .slave_sel(sel0), .trans_done(td0),
    .slave_split_en(sp0), .grant(g0), .granted_slave(gs0), .arbiter_busy(ab0),
    .bus_busy(bb0), .split_parked(spk0), .timeout(to0));

  bus_arbiter_n #(.NUM_MASTERS(3), .NUM_SLAVES(3), .SLAVE_LEN(2), .RR_MODE(1), .MAX_HOLD(5)) dut1 (
    .clk(clk), .reset(rst1), .request(req1), .slave_sel(sel1), .trans_done(td1),
    .slave_split_en(sp1), .grant(g1), .granted_slave(gs1), .arbiter_busy(ab1),
    .bus_busy(bb1), .split_parked(spk1), .timeout(to1));

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit       owned;
    int       owner;
    int       oslave;
    bit [7:0] parked;
    int       pslave [8];
    int       rr;
    int       hold;
    bit       tmo;
  } mdl_t;

  mdl_t m0, m1;

  function automatic bit taken(input mdl_t s, input int n, input int slv);
    for (int j = 0; j < n; j++)
      if (s.parked[j] && s.pslave[j] == slv) return 1'b1;
    return 1'b0;
  endfunction

  function automatic mdl_t mstep(input mdl_t s, input int n, input bit rrm, input int h,
                                 input bit rst, input bit [7:0] req, input bit [15:0] sel,
                                 input bit td, input bit [2:0] split);
    mdl_t t;
    int   w, si, idx;
    bit   res;
    t = s;
    t.tmo = 1'b0;
    if (rst) begin
      t.owned = 0; t.owner = 0; t.oslave = 0; t.parked = '0;
      for (int i = 0; i < 8; i++) t.pslave[i] = 0;
      t.rr = 0; t.hold = 0;
      return t;
    end
    if (!s.owned) begin
      w = -1; res = 0;
      for (int i = 0; i < n; i++)
        if (w < 0 && s.parked[i] && !split[s.pslave[i]]) begin w = i; res = 1; end
      for (int k = 0; k < n; k++) begin
        idx = rrm ? (s.rr + k) % n : k;
        si  = int'(sel[2*idx +: 2]);
        if (w < 0 && req[idx] && !s.parked[idx] && si < 3 && !taken(s, n, si)) w = idx;
      end
      if (w >= 0) begin
        t.owned = 1; t.owner = w; t.hold = 0;
        if (res) begin t.oslave = s.pslave[w]; t.parked[w] = 0; end
        else t.oslave = int'(sel[2*w +: 2]);
      end
    end else begin
      if (td) begin
        t.owned = 0; t.rr = (s.owner + 1) % n;
      end else if (split[s.oslave]) begin
        t.owned = 0; t.parked[s.owner] = 1; t.pslave[s.owner] = s.oslave;
      end else if (h != 0 && s.hold == h - 1) begin
        t.owned = 0; t.tmo = 1; t.rr = (s.owner + 1) % n;
      end else if (s.hold < 65535) begin
        t.hold = s.hold + 1;
      end
    end
    return t;
  endfunction

  function automatic logic [20:0] pk(input bit to, input bit [7:0] spk, input bit bb,
                                     input bit ab, input bit [1:0] gs, input bit [7:0] g);
    return {to, spk, bb, ab, gs, g};
  endfunction

  function automatic logic [20:0] mexp(input mdl_t s);
    bit [7:0] g;
    bit [1:0] gs;
    g  = s.owned ? 8'(1 << s.owner) : 8'd0;
    gs = s.owned ? 2'(s.oslave) : 2'd0;
    return pk(s.tmo, s.parked, s.owned || (s.parked != 0), s.owned, gs, g);
  endfunction

  task automatic chk(input string nm, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One clock: the model sees the same inputs the DUTs sample at the edge.
  task automatic tick();
    @(posedge clk);
    m0 = mstep(m0, 2, 1'b0, 0, rst0, 8'(req0), 16'(sel0), td0, sp0);
    m1 = mstep(m1, 3, 1'b1, 5, rst1, 8'(req1), 16'(sel1), td1, sp1);
    #1;
  endtask

  function automatic logic [20:0] act0();
    return pk(to0, 8'(spk0), bb0, ab0, gs0, 8'(g0));
  endfunction

  function automatic logic [20:0] act1();
    return pk(to1, 8'(spk1), bb1, ab1, gs1, 8'(g1));
  endfunction

  // ---------------- directed vector table (instance 0) ----------------
  typedef struct packed {
    logic       rst;
    logic [1:0] req;
    logic [3:0] sel;
    logic       td;
    logic [2:0] split;
    logic [1:0] g;
    logic [1:0] gs;
    logic       ab;
    logic       bb;
    logic [1:0] sp;
    logic       to;
  } vec_t;

  vec_t tbl [28];

  initial begin
    int expg;
    // rst req  sel      td split   | g     gs    ab bb sp    to
    tbl[0]  = '{1, 2'b11, 4'b1001, 0, 3'b000, 2'b00, 2'd0, 0, 0, 2'b00, 0}; // reset
    tbl[1]  = '{0, 2'b11, 4'b1001, 0, 3'b000, 2'b01, 2'd1, 1, 1, 2'b00, 0}; // fixed prio
    tbl[2]  = '{0, 2'b11, 4'b1001, 0, 3'b000, 2'b01, 2'd1, 1, 1, 2'b00, 0};
    tbl[3]  = '{0, 2'b10, 4'b1001, 1, 3'b000, 2'b00, 2'd0, 0, 0, 2'b00, 0}; // done
    tbl[4]  = '{0, 2'b10, 4'b1001, 0, 3'b000, 2'b10, 2'd2, 1, 1, 2'b00, 0};
    tbl[5]  = '{0, 2'b00, 4'b1001, 1, 3'b000, 2'b00, 2'd0, 0, 0, 2'b00, 0};
    tbl[6]  = '{0, 2'b01, 4'b1001, 0, 3'b000, 2'b01, 2'd1, 1, 1, 2'b00, 0};
    tbl[7]  = '{0, 2'b00, 4'b1001, 0, 3'b000, 2'b01, 2'd1, 1, 1, 2'b00, 0}; // drop req holds
    tbl[8]  = '{0, 2'b00, 4'b1001, 0, 3'b010, 2'b00, 2'd0, 0, 1, 2'b01, 0}; // split park
    tbl[9]  = '{0, 2'b10, 4'b1001, 0, 3'b010, 2'b10, 2'd2, 1, 1, 2'b01, 0};
    tbl[10] = '{0, 2'b00, 4'b1001, 1, 3'b010, 2'b00, 2'd0, 0, 1, 2'b01, 0};
    tbl[11] = '{0, 2'b10, 4'b0101, 0, 3'b010, 2'b00, 2'd0, 0, 1, 2'b01, 0}; // slave1 blocked
    tbl[12] = '{0, 2'b10, 4'b0101, 0, 3'b010, 2'b00, 2'd0, 0, 1, 2'b01, 0};
    tbl[13] = '{0, 2'b10, 4'b1001, 0, 3'b010, 2'b10, 2'd2, 1, 1, 2'b01, 0};
    tbl[14] = '{0, 2'b10, 4'b1001, 0, 3'b000, 2'b10, 2'd2, 1, 1, 2'b01, 0};
    tbl[15] = '{0, 2'b10, 4'b1001, 1, 3'b000, 2'b00, 2'd0, 0, 1, 2'b01, 0};
    tbl[16] = '{0, 2'b10, 4'b1001, 0, 3'b000, 2'b01, 2'd1, 1, 1, 2'b00, 0}; // resume wins
    tbl[17] = '{0, 2'b00, 4'b1001, 1, 3'b000, 2'b00, 2'd0, 0, 0, 2'b00, 0};
    tbl[18] = '{0, 2'b01, 4'b1001, 0, 3'b000, 2'b01, 2'd1, 1, 1, 2'b00, 0};
    tbl[19] = '{0, 2'b00, 4'b1001, 1, 3'b010, 2'b00, 2'd0, 0, 0, 2'b00, 0}; // done+split
    tbl[20] = '{0, 2'b00, 4'b1001, 0, 3'b000, 2'b00, 2'd0, 0, 0, 2'b00, 0};
    tbl[21] = '{0, 2'b01, 4'b1011, 0, 3'b000, 2'b00, 2'd0, 0, 0, 2'b00, 0}; // sel=3
    tbl[22] = '{0, 2'b01, 4'b1011, 0, 3'b000, 2'b00, 2'd0, 0, 0, 2'b00, 0};
    tbl[23] = '{0, 2'b01, 4'b1001, 0, 3'b000, 2'b01, 2'd1, 1, 1, 2'b00, 0};
    tbl[24] = '{0, 2'b00, 4'b1001, 0, 3'b010, 2'b00, 2'd0, 0, 1, 2'b01, 0};
    tbl[25] = '{0, 2'b10, 4'b1001, 0, 3'b010, 2'b10, 2'd2, 1, 1, 2'b01, 0};
    tbl[26] = '{1, 2'b10, 4'b1001, 0, 3'b010, 2'b00, 2'd0, 0, 0, 2'b00, 0}; // reset mid-own
    tbl[27] = '{0, 2'b00, 4'b1001, 0, 3'b000, 2'b00, 2'd0, 0, 0, 2'b00, 0};

    // reset both instances and check the reset state
    rst0 = 1; req0 = 2'b11; sel0 = 4'b1001; td0 = 0; sp0 = 3'b000;
    rst1 = 1; req1 = 3'b111; sel1 = 6'b100100; td1 = 0; sp1 = 3'b000;
    tick();
    chk("reset0", act0(), 21'd0);
    chk("reset1", act1(), 21'd0);
    req1 = 3'b000;
    rst1 = 0;

    // instance 0 table
    for (int r = 0; r < 28; r++) begin
      rst0 = tbl[r].rst; req0 = tbl[r].req; sel0 = tbl[r].sel;
      td0 = tbl[r].td; sp0 = tbl[r].split;
      tick();
      chk($sformatf("vec%0d", r), act0(),
          pk(tbl[r].to, 8'(tbl[r].sp), tbl[r].bb, tbl[r].ab, tbl[r].gs, 8'(tbl[r].g)));
    end
    rst0 = 0; req0 = 0; td0 = 0; sp0 = 0;

    // round robin on instance 1: trans_done every 4th cycle
    rst1 = 1; tick(); rst1 = 0;
    req1 = 3'b111;
    for (int c = 1; c <= 15; c++) begin
      td1 = ((c % 4) == 0);
      tick();
      expg = ((c % 4) == 0) ? 0 : (1 << (((c - 1) / 4) % 3));
      chk($sformatf("rr_c%0d", c), 21'(g1), 21'(expg));
    end
    td1 = 0;

    // timeout on instance 1: master 1 holds slave 1 with no trans_done
    rst1 = 1; tick(); rst1 = 0;
    req1 = 3'b010;
    for (int c = 1; c <= 7; c++) begin
      if (c == 7) req1 = 3'b111;
      tick();
      if (c <= 5)      chk($sformatf("tmo_c%0d", c), act1(), pk(0, 0, 1, 1, 2'd1, 8'b010));
      else if (c == 6) chk("tmo_pulse", act1(), pk(1, 0, 0, 0, 2'd0, 8'b000));
      else             chk("tmo_rrnext", act1(), pk(0, 0, 1, 1, 2'd2, 8'b100));
    end

    // random stimulus against the model
    rst0 = 1; rst1 = 1; req0 = 0; req1 = 0; td0 = 0; td1 = 0; sp0 = 0; sp1 = 0;
    tick();
    for (int c = 0; c < 1500; c++) begin
      rst0 = ($urandom_range(0, 99) == 0);
      rst1 = ($urandom_range(0, 99) == 0);
      req0 = 2'($urandom);
      req1 = 3'($urandom);
      sel0 = 4'($urandom);
      sel1 = 6'($urandom);
      td0  = ($urandom_range(0, 3) == 0);
      td1  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        for (int b = 0; b < 3; b++) sp0[b] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0)
        for (int b = 0; b < 3; b++) sp1[b] = ($urandom_range(0, 2) == 0);
      tick();
      chk($sformatf("rand0_%0d", c), act0(), mexp(m0));
      chk($sformatf("rand1_%0d", c), act1(), mexp(m1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_n.md
# bus_arbiter_n

Parametrised N-master, M-slave bus arbiter with split-transaction support. It replaces the fixed two-master arbiter inside the bus interconnect. It accepts per-master requests with a parallel slave select, grants exactly one master at a time, and reports the owning slave to the interconnect's data-path muxes. It also parks masters whose slave asserts split, resumes them with top priority, and enforces an optional bus-hold timeout.

## Interface
- NUM_MASTERS, 2: number of masters, 2..8.
- NUM_SLAVES, 3: number of slaves; valid slave_sel values are 0..NUM_SLAVES-1.
- SLAVE_LEN, 2: width of each slave select; must satisfy 2^SLAVE_LEN >= NUM_SLAVES.
- RR_MODE, 0: arbitration mode; 0 = fixed priority (lowest index wins), 1 = round robin.
- MAX_HOLD, 0: maximum cycles a grant may be held without trans_done; 0 disables the timeout. The counter is 16 bits.
- clk  in  1  system clock; the single clock for the block.
- reset  in  1  synchronous, active-high reset.
- request  in  NUM_MASTERS  per-master bus request, level.
- slave_sel  in  NUM_MASTERS*SLAVE_LEN  target slave; master i uses bits [i*SLAVE_LEN +: SLAVE_LEN].
- trans_done  in  1  one-cycle pulse from the owning master at the end of a transaction.
- slave_split_en  in  NUM_SLAVES  level; bit s high means slave s requests a split.
- grant  out  NUM_MASTERS  one-hot or zero; the current bus owner.
- granted_slave  out  SLAVE_LEN  slave index of the current owner; 0 when idle.
- arbiter_busy  out  1  high while a grant is active.
- bus_busy  out  1  arbiter_busy OR any master parked.
- split_parked  out  NUM_MASTERS  per-master parked flag.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- States: IDLE and OWNED.
- Per-master storage: parked[i] and park_slave[i]. Shared registers: owner, owner_slave, rr_ptr, hold_cnt.
- A master is **eligible** in IDLE when all of the following hold:
  - request[i]=1 and parked[i]=0;
  - slave_sel[i] < NUM_SLAVES;
  - the selected slave is not park_slave of any parked master.
- A master is **resumable** when parked[i]=1 and slave_split_en[park_slave[i]]=0. A resumable master needs no request.
- IDLE -> OWNED when at least one master is resumable or eligible. Winner selection:
  - The lowest-index resumable master always wins. It is re-granted with owner_slave = park_slave, and parked[i] is cleared.
  - Otherwise, the winner is the lowest-index eligible master (RR_MODE=0), or the first eligible master at or above rr_ptr with wrap-around (RR_MODE=1).
  - hold_cnt is cleared on entry.
- In OWNED, the first matching condition applies:
  - trans_done=1 -> IDLE. rr_ptr becomes (owner+1) mod NUM_MASTERS.
  - slave_split_en[owner_slave]=1 -> IDLE. Set parked[owner]=1 and park_slave[owner]=owner_slave. rr_ptr is unchanged.
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> IDLE. Pulse timeout. rr_ptr becomes owner+1.
  - Otherwise, stay in OWNED and increment hold_cnt, saturating.
- Dropping a request while OWNED does not release the grant. A grant is released only by one of the three exits above.
- trans_done in IDLE is ignored.
- A slave_sel change while OWNED is ignored; owner_slave is latched at grant.
- Reset clears all state:
  - outputs: grant=0, granted_slave=0, arbiter_busy=0, bus_busy=0, split_parked=0, timeout=0;
  - internal: rr_ptr=0, hold_cnt=0, state=IDLE.
  - Reset wins over every other event, including reset asserted mid-transaction or while masters are parked.

## Timing
- All outputs are registered and change only on the rising edge of clk.
- Grant latency: request sampled high in IDLE at edge k -> grant and arbiter_busy high after edge k.
- Release: an exit event sampled at edge k -> grant=0 after edge k.
- IDLE lasts at least one cycle. Back-to-back ownership therefore has one dead cycle: trans_done sampled at edge k, next grant after edge k+1.
- Timeout with MAX_HOLD=H: grant remains high for exactly H cycles, then drops. timeout is high for the first cycle after the drop.
- A split deassertion sampled at edge k, while in IDLE -> resumed grant after edge k.

## Test plan
- Fixed priority: RR_MODE=0; request=2'b11 with sel0=1, sel1=2 -> grant=01 and granted_slave=1 one cycle later. After trans_done: one idle cycle, then grant=10 and granted_slave=2.
- Round robin: RR_MODE=1, NUM_MASTERS=3; all three masters request continuously and trans_done pulses every 4 cycles -> grant sequence 001,010,100,001, with a single-cycle zero between grants.
- Split: master 0 owns slave 1 and slave_split_en[1] rises -> grant=0, split_parked=01, bus_busy=1. Master 1 requesting slave 2 is then granted. A master 1 request to slave 1 is blocked. After slave_split_en[1] falls and master 1 completes -> master 0 is re-granted with granted_slave=1 without asserting request.
- Timeout: MAX_HOLD=5; master 1 holds without trans_done -> grant high for 5 cycles, then timeout pulses for 1 cycle and rr_ptr advances.
- Boundaries:
  - slave_sel=3 with NUM_SLAVES=3 -> request ignored, grant stays 0.
  - trans_done and split in the same cycle -> no park.
  - reset while OWNED with one master parked -> all outputs 0 on the next cycle.
